// File: rtl/bp_lce_cache_req_queue_pkg.sv
// Local types and defaults shared by the cache request queue and its storage slots.
// Nothing here is exported beyond the queue itself.
package bp_lce_cache_req_queue_pkg;

  // The queue holds ready low for one edge after reset so the upstream cache
  // sees a clean startup before its first request is accepted.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } q_state_e;

  localparam int unsigned DEF_ELS       = 2;
  localparam int unsigned DEF_REQ_WIDTH = 8;
  localparam int unsigned DEF_MD_WIDTH  = 8;

endpackage

// File: rtl/bp_lce_cache_req_queue_entry.sv
// One storage slot of the cache request queue: request payload, metadata payload
// and their valid bits. Clear wins over a same-cycle metadata write.
module bp_lce_cache_req_queue_entry
  import bp_lce_cache_req_queue_pkg::*;
#(
  parameter int unsigned req_width_p = DEF_REQ_WIDTH,
  parameter int unsigned md_width_p  = DEF_MD_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   set_i,
  input  logic                   md_set_i,
  input  logic                   clear_i,
  input  logic [req_width_p-1:0] req_i,
  input  logic [md_width_p-1:0]  md_i,
  output logic                   valid_o,
  output logic                   md_valid_o,
  output logic [req_width_p-1:0] req_o,
  output logic [md_width_p-1:0]  md_o
);

  logic                   valid_q, valid_d;
  logic                   md_valid_q, md_valid_d;
  logic [req_width_p-1:0] req_q, req_d;
  logic [md_width_p-1:0]  md_q, md_d;

  always_comb begin
    valid_d    = valid_q;
    md_valid_d = md_valid_q;
    req_d      = req_q;
    md_d       = md_q;

    if (clear_i) begin
      valid_d    = 1'b0;
      md_valid_d = 1'b0;
    end else if (set_i) begin
      valid_d    = 1'b1;
      md_valid_d = md_set_i;
    end else if (md_set_i) begin
      md_valid_d = 1'b1;
    end

    if (set_i) begin
      req_d = req_i;
    end
    if (md_set_i && !clear_i) begin
      md_d = md_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      valid_q    <= 1'b0;
      md_valid_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      md_valid_q <= md_valid_d;
    end
  end

  // Payload is qualified by the valid bits, so it needs no reset.
  always_ff @(posedge clk_i) begin
    req_q <= req_d;
    md_q  <= md_d;
  end

  assign valid_o    = valid_q;
  assign md_valid_o = md_valid_q;
  assign req_o      = req_q;
  assign md_o       = md_q;

endmodule

// File: rtl/bp_lce_cache_req_queue.sv
// Decoupling queue between the cache miss pipeline and the LCE request engine.
// Requests are presented to the LCE only once their metadata is known (stored or bypassed).
module bp_lce_cache_req_queue
  import bp_lce_cache_req_queue_pkg::*;
#(
  parameter int unsigned els_p       = DEF_ELS,
  parameter int unsigned req_width_p = DEF_REQ_WIDTH,
  parameter int unsigned md_width_p  = DEF_MD_WIDTH
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic [req_width_p-1:0]       cache_req_i,
  input  logic                         cache_req_v_i,
  output logic                         cache_req_ready_o,
  input  logic [md_width_p-1:0]        cache_md_i,
  input  logic                         cache_md_v_i,
  output logic [req_width_p-1:0]       lce_req_o,
  output logic [md_width_p-1:0]        lce_md_o,
  output logic                         lce_req_v_o,
  input  logic                         lce_req_yumi_i,
  output logic [$clog2(els_p+1)-1:0]   count_o
);

  localparam int unsigned ptr_w_lp = $clog2(els_p);
  localparam int unsigned cnt_w_lp = $clog2(els_p + 1);

  q_state_e              state_q, state_d;
  logic [ptr_w_lp-1:0]   wptr_q, wptr_d;
  logic [ptr_w_lp-1:0]   rptr_q, rptr_d;
  logic [ptr_w_lp-1:0]   wptr_last;
  logic [cnt_w_lp-1:0]   count_q, count_d;

  logic [els_p-1:0]       valid_v;
  logic [els_p-1:0]       md_valid_v;
  logic [els_p-1:0]       set_v;
  logic [els_p-1:0]       md_set_v;
  logic [els_p-1:0]       clear_v;
  logic [req_width_p-1:0] req_a [els_p];
  logic [md_width_p-1:0]  md_a  [els_p];

  logic full;
  logic pending_md;
  logic head_is_pending;
  logic md_bypass;
  logic enq;
  logic deq;
  logic md_late;

  // The only entry that can lack metadata is the most recently enqueued one,
  // because ready stays low until that entry's metadata arrives.
  assign wptr_last       = wptr_q - ptr_w_lp'(1);
  assign full            = (count_q == cnt_w_lp'(els_p));
  assign pending_md      = valid_v[wptr_last] & ~md_valid_v[wptr_last];
  assign head_is_pending = pending_md & (rptr_q == wptr_last);
  assign md_bypass       = cache_md_v_i & head_is_pending;

  assign cache_req_ready_o = (state_q == ST_RUN) & ~full & ~pending_md;
  assign enq               = cache_req_v_i & cache_req_ready_o;
  assign md_late           = cache_md_v_i & ~enq & pending_md;

  assign lce_req_v_o = valid_v[rptr_q] & (md_valid_v[rptr_q] | md_bypass);
  assign lce_req_o   = req_a[rptr_q];
  assign lce_md_o    = md_bypass ? cache_md_i : md_a[rptr_q];
  assign deq         = lce_req_yumi_i & lce_req_v_o;
  assign count_o     = count_q;

  genvar gi;
  generate
    for (gi = 0; gi < els_p; gi++) begin : g_entry
      assign set_v[gi]    = enq & (wptr_q == ptr_w_lp'(gi));
      assign md_set_v[gi] = (enq & cache_md_v_i & (wptr_q == ptr_w_lp'(gi)))
                          | (md_late & (wptr_last == ptr_w_lp'(gi)));
      assign clear_v[gi]  = deq & (rptr_q == ptr_w_lp'(gi));

      bp_lce_cache_req_queue_entry #(
        .req_width_p (req_width_p),
        .md_width_p  (md_width_p)
      ) u_entry (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .set_i      (set_v[gi]),
        .md_set_i   (md_set_v[gi]),
        .clear_i    (clear_v[gi]),
        .req_i      (cache_req_i),
        .md_i       (cache_md_i),
        .valid_o    (valid_v[gi]),
        .md_valid_o (md_valid_v[gi]),
        .req_o      (req_a[gi]),
        .md_o       (md_a[gi])
      );
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;

    case (state_q)
      ST_INIT: state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase

    if (enq) begin
      wptr_d = wptr_q + ptr_w_lp'(1);
    end
    if (deq) begin
      rptr_d = rptr_q + ptr_w_lp'(1);
    end

    case ({enq, deq})
      2'b10:   count_d = count_q + cnt_w_lp'(1);
      2'b01:   count_d = count_q - cnt_w_lp'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ST_INIT;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  a_yumi_needs_valid : assert property (
    @(posedge clk_i) disable iff (!reset_n_i) lce_req_yumi_i |-> lce_req_v_o
  );

  a_count_bounded : assert property (
    @(posedge clk_i) disable iff (!reset_n_i) count_q <= cnt_w_lp'(els_p)
  );

endmodule

// File: tb/tb_bp_lce_cache_req_queue.sv
// Directed bench for bp_lce_cache_req_queue with els_p=2 and 8-bit request/metadata.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
module tb_bp_lce_cache_req_queue;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] cache_req;
  logic       cache_req_v;
  logic       cache_req_ready;
  logic [7:0] cache_md;
  logic       cache_md_v;
  logic [7:0] lce_req;
  logic [7:0] lce_md;
  logic       lce_req_v;
  logic       lce_req_yumi;
  logic [1:0] count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bp_lce_cache_req_queue #(
    .els_p       (2),
    .req_width_p (8),
    .md_width_p  (8)
  ) dut (
    .clk_i             (clk),
    .reset_n_i         (reset_n),
    .cache_req_i       (cache_req),
    .cache_req_v_i     (cache_req_v),
    .cache_req_ready_o (cache_req_ready),
    .cache_md_i        (cache_md),
    .cache_md_v_i      (cache_md_v),
    .lce_req_o         (lce_req),
    .lce_md_o          (lce_md),
    .lce_req_v_o       (lce_req_v),
    .lce_req_yumi_i    (lce_req_yumi),
    .count_o           (count)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    cache_req_v  = 1'b0;
    cache_md_v   = 1'b0;
    lce_req_yumi = 1'b0;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    cache_req = 8'h00;
    cache_md  = 8'h00;
    drive_idle();
    #1;
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (cache_req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", cache_req_ready); end
    checks++; if (lce_req_v !== 1'b0) begin errors++; $display("FAIL reset_lce_v: got %b expected 0", lce_req_v); end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++; if (cache_req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_pre_edge: got %b expected 0", cache_req_ready); end
    next_cycle();
    checks++; if (cache_req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_first_edge: got %b expected 1", cache_req_ready); end
    $display("reset released: ready=%b count=%0d", cache_req_ready, count);
  endtask

  task automatic test_same_cycle_md();
    cache_req_v = 1'b1; cache_req = 8'h11; cache_md_v = 1'b1; cache_md = 8'hA1;
    #1;
    checks++; if (lce_req_v !== 1'b0) begin errors++; $display("FAIL t1_no_comb_path: got %b expected 0", lce_req_v); end
    next_cycle();
    drive_idle(); lce_req_yumi = 1'b1;
    #1;
    checks++; if (lce_req_v !== 1'b1) begin errors++; $display("FAIL t1_v: got %b expected 1", lce_req_v); end
    checks++; if (lce_req !== 8'h11) begin errors++; $display("FAIL t1_req: got %h expected 11", lce_req); end
    checks++; if (lce_md !== 8'hA1) begin errors++; $display("FAIL t1_md: got %h expected a1", lce_md); end
    checks++; if (count !== 2'd1) begin errors++; $display("FAIL t1_count1: got %0d expected 1", count); end
    $display("deq: req=%h md=%h", lce_req, lce_md);
    next_cycle();
    drive_idle();
    #1;
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL t1_count0: got %0d expected 0", count); end
    checks++; if (lce_req_v !== 1'b0) begin errors++; $display("FAIL t1_v_after: got %b expected 0", lce_req_v); end
  endtask

  task automatic test_late_md();
    next_cycle();
    cache_req_v = 1'b1; cache_req = 8'h22; cache_md_v = 1'b0;
    #1;
    checks++; if (cache_req_ready !== 1'b1) begin errors++; $display("FAIL t2_ready_enq: got %b expected 1", cache_req_ready); end
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      drive_idle();
      #1;
      checks++; if (cache_req_ready !== 1'b0) begin errors++; $display("FAIL t2_ready_wait%0d: got %b expected 0", i, cache_req_ready); end
      checks++; if (lce_req_v !== 1'b0) begin errors++; $display("FAIL t2_v_wait%0d: got %b expected 0", i, lce_req_v); end
    end
    next_cycle();
    cache_md_v = 1'b1; cache_md = 8'hB2; lce_req_yumi = 1'b1;
    #1;
    checks++; if (lce_req_v !== 1'b1) begin errors++; $display("FAIL t2_bypass_v: got %b expected 1", lce_req_v); end
    checks++; if (lce_req !== 8'h22) begin errors++; $display("FAIL t2_req: got %h expected 22", lce_req); end
    checks++; if (lce_md !== 8'hB2) begin errors++; $display("FAIL t2_bypass_md: got %h expected b2", lce_md); end
    $display("deq: req=%h md=%h (bypass)", lce_req, lce_md);
    next_cycle();
    drive_idle();
    #1;
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL t2_count0: got %0d expected 0", count); end
    checks++; if (lce_req_v !== 1'b0) begin errors++; $display("FAIL t2_v_after: got %b expected 0", lce_req_v); end
    checks++; if (cache_req_ready !== 1'b1) begin errors++; $display("FAIL t2_ready_after: got %b expected 1", cache_req_ready); end
  endtask

  task automatic test_fill();
    next_cycle();
    cache_req_v = 1'b1; cache_req = 8'h33; cache_md_v = 1'b1; cache_md = 8'hC3;
    #1;
    checks++; if (cache_req_ready !== 1'b1) begin errors++; $display("FAIL t3_ready_c: got %b expected 1", cache_req_ready); end
    next_cycle();
    cache_req = 8'h44; cache_md = 8'hD4;
    #1;
    checks++; if (cache_req_ready !== 1'b1) begin errors++; $display("FAIL t3_ready_d: got %b expected 1", cache_req_ready); end
    checks++; if (lce_req !== 8'h33) begin errors++; $display("FAIL t3_head_c_early: got %h expected 33", lce_req); end
    next_cycle();
    drive_idle();
    #1;
    checks++; if (count !== 2'd2) begin errors++; $display("FAIL t3_count2: got %0d expected 2", count); end
    checks++; if (cache_req_ready !== 1'b0) begin errors++; $display("FAIL t3_ready_full: got %b expected 0", cache_req_ready); end
    checks++; if (lce_req_v !== 1'b1 || lce_req !== 8'h33 || lce_md !== 8'hC3) begin
      errors++; $display("FAIL t3_head_c: got v=%b req=%h md=%h expected v=1 req=33 md=c3", lce_req_v, lce_req, lce_md);
    end
  endtask

  task automatic test_full_yumi_enq();
    next_cycle();
    lce_req_yumi = 1'b1; cache_req_v = 1'b1; cache_req = 8'h55; cache_md_v = 1'b0;
    #1;
    checks++; if (cache_req_ready !== 1'b0) begin errors++; $display("FAIL t4_ready_full: got %b expected 0", cache_req_ready); end
    $display("deq: req=%h md=%h", lce_req, lce_md);
    next_cycle();
    cache_md_v = 1'b1; cache_md = 8'hE5;
    #1;
    checks++; if (count !== 2'd1) begin errors++; $display("FAIL t4_count_after_pop: got %0d expected 1", count); end
    checks++; if (cache_req_ready !== 1'b1) begin errors++; $display("FAIL t4_ready_after_pop: got %b expected 1", cache_req_ready); end
    checks++; if (lce_req_v !== 1'b1 || lce_req !== 8'h44 || lce_md !== 8'hD4) begin
      errors++; $display("FAIL t4_head_d: got v=%b req=%h md=%h expected v=1 req=44 md=d4", lce_req_v, lce_req, lce_md);
    end
    $display("deq: req=%h md=%h", lce_req, lce_md);
    next_cycle();
    drive_idle(); lce_req_yumi = 1'b1;
    #1;
    checks++; if (count !== 2'd1) begin errors++; $display("FAIL t4_count_enq_deq: got %0d expected 1", count); end
    checks++; if (lce_req_v !== 1'b1 || lce_req !== 8'h55 || lce_md !== 8'hE5) begin
      errors++; $display("FAIL t4_head_e: got v=%b req=%h md=%h expected v=1 req=55 md=e5", lce_req_v, lce_req, lce_md);
    end
    $display("deq: req=%h md=%h", lce_req, lce_md);
    next_cycle();
    drive_idle();
    #1;
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL t4_count0: got %0d expected 0", count); end
  endtask

  task automatic test_async_reset();
    next_cycle();
    cache_req_v = 1'b1; cache_req = 8'h66; cache_md_v = 1'b1; cache_md = 8'hF6;
    next_cycle();
    cache_req = 8'h77; cache_md = 8'hF7;
    next_cycle();
    drive_idle();
    #1;
    checks++; if (count !== 2'd2) begin errors++; $display("FAIL t5_count2: got %0d expected 2", count); end
    #1;
    reset_n = 1'b0;
    #1;
    checks++; if (lce_req_v !== 1'b0) begin errors++; $display("FAIL t5_v_async: got %b expected 0", lce_req_v); end
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL t5_count_async: got %0d expected 0", count); end
    checks++; if (cache_req_ready !== 1'b0) begin errors++; $display("FAIL t5_ready_async: got %b expected 0", cache_req_ready); end
    @(negedge clk);
    reset_n = 1'b1;
    next_cycle();
    checks++; if (cache_req_ready !== 1'b1) begin errors++; $display("FAIL t5_ready_release: got %b expected 1", cache_req_ready); end
    checks++; if (lce_req_v !== 1'b0) begin errors++; $display("FAIL t5_v_release: got %b expected 0", lce_req_v); end
    $display("reset mid-operation: count=%0d ready=%b", count, cache_req_ready);
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_req;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) next_cycle();
      if (k < 7) begin
        cache_req_v = 1'b1; cache_req = 8'(k); cache_md_v = 1'b1; cache_md = 8'(k) | 8'h80;
      end else begin
        cache_req_v = 1'b0; cache_md_v = 1'b0;
      end
      lce_req_yumi = (k > 0);
      #1;
      if (k < 7) begin
        checks++; if (cache_req_ready !== 1'b1) begin errors++; $display("FAIL t6_ready_%0d: got %b expected 1", k, cache_req_ready); end
      end
      if (k > 0) begin
        exp_req = 8'(k - 1);
        checks++; if (lce_req_v !== 1'b1 || lce_req !== exp_req || lce_md !== (exp_req | 8'h80)) begin
          errors++; $display("FAIL t6_out_%0d: got v=%b req=%h md=%h expected v=1 req=%h md=%h",
                             k - 1, lce_req_v, lce_req, lce_md, exp_req, exp_req | 8'h80);
        end
        $display("deq: req=%h md=%h", lce_req, lce_md);
      end
    end
    next_cycle();
    drive_idle();
    #1;
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL t6_count0: got %0d expected 0", count); end
    checks++; if (lce_req_v !== 1'b0) begin errors++; $display("FAIL t6_v_after: got %b expected 0", lce_req_v); end
  endtask

  initial begin
    test_reset();
    test_same_cycle_md();
    test_late_md();
    test_fill();
    test_full_yumi_enq();
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
